// File: rtl/read_ptr_ctrl.sv
// Read-side pointer controller for an async FIFO: binary/gray read pointers, read address,
// registered empty / almost-empty / level flags. Optional sticky underflow via RD_PTR_UNDERFLOW_EN.
module read_ptr_ctrl #(
    parameter int ADDR_SIZE = 4,
    parameter int AE_THRESH = 2
) (
    input  logic                 i_rd_clk,
    input  logic                 i_rdrst,
    input  logic                 i_rd_inc,
    input  logic                 i_rd_flush,
    input  logic [ADDR_SIZE:0]   i_gray_q2_wrptr,
    output logic [ADDR_SIZE-1:0] o_rd_addr,
    output logic [ADDR_SIZE:0]   o_gray_rdptr,
    output logic                 o_rd_empty,
    output logic                 o_rd_almost_empty,
    output logic [ADDR_SIZE:0]   o_rd_level,
    output logic                 o_rd_underflow
);

    localparam int PW = ADDR_SIZE + 1;
    localparam logic [PW-1:0] AE_LIMIT = PW'(AE_THRESH);

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    logic [PW-1:0] rd_bin;
    logic [PW-1:0] wq_bin;
    logic [PW-1:0] rd_bin_next;
    logic [PW-1:0] rd_gray_next;
    logic [PW-1:0] level_next;
    logic          pop;

    // Next-state: flush overrides any pop issued in the same cycle
    always_comb begin
        wq_bin       = gray2bin(i_gray_q2_wrptr);
        pop          = i_rd_inc & ~o_rd_empty;
        rd_bin_next  = i_rd_flush ? wq_bin : rd_bin + {{ADDR_SIZE{1'b0}}, pop};
        rd_gray_next = bin2gray(rd_bin_next);
        level_next   = wq_bin - rd_bin_next;
    end

    // Registered pointers and flags, all derived from the next pointer so they agree each cycle
    always_ff @(posedge i_rd_clk) begin
        if (i_rdrst) begin
            rd_bin            <= '0;
            o_gray_rdptr      <= '0;
            o_rd_empty        <= 1'b1;
            o_rd_almost_empty <= 1'b1;
            o_rd_level        <= '0;
        end else begin
            rd_bin            <= rd_bin_next;
            o_gray_rdptr      <= rd_gray_next;
            o_rd_empty        <= (rd_gray_next == i_gray_q2_wrptr);
            o_rd_almost_empty <= (level_next <= AE_LIMIT);
            o_rd_level        <= level_next;
        end
    end

    assign o_rd_addr = rd_bin[ADDR_SIZE-1:0];

`ifdef RD_PTR_UNDERFLOW_EN
    logic underflow;

    always_ff @(posedge i_rd_clk) begin
        if (i_rdrst) begin
            underflow <= 1'b0;
        end else if (i_rd_inc && o_rd_empty) begin
            underflow <= 1'b1;
        end
    end

    assign o_rd_underflow = underflow;
`else
    assign o_rd_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_read_ptr_ctrl.sv
// Directed table-driven bench for read_ptr_ctrl (ADDR_SIZE=4, AE_THRESH=2), plus a wrap sequence.
module tb_read_ptr_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       inc;
    logic       flush;
    logic [4:0] wg;
    logic [3:0] addr;
    logic [4:0] gray;
    logic       empty;
    logic       ae;
    logic [4:0] level;
    logic       uf;

    int pass_cnt = 0;
    int total    = 0;

`ifdef RD_PTR_UNDERFLOW_EN
    localparam bit UFE = 1'b1;
`else
    localparam bit UFE = 1'b0;
`endif

    read_ptr_ctrl #(.ADDR_SIZE(4), .AE_THRESH(2)) dut (
        .i_rd_clk          (clk),
        .i_rdrst           (rst),
        .i_rd_inc          (inc),
        .i_rd_flush        (flush),
        .i_gray_q2_wrptr   (wg),
        .o_rd_addr         (addr),
        .o_gray_rdptr      (gray),
        .o_rd_empty        (empty),
        .o_rd_almost_empty (ae),
        .o_rd_level        (level),
        .o_rd_underflow    (uf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       inc;
        logic       flush;
        logic [4:0] wg;
        logic       e;
        logic       ae;
        logic [4:0] lvl;
        logic [3:0] addr;
        logic [4:0] g;
        logic       uf;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] to_gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    initial begin
        // rst inc flush wrgray | empty ae level addr gray uf(if enabled)
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 5'b00000, 1'b1, 1'b1, 5'd0,  4'd0, 5'b00000, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 5'b00000, 1'b1, 1'b1, 5'd0,  4'd0, 5'b00000, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 5'b00111, 1'b0, 1'b0, 5'd5,  4'd0, 5'b00000, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 5'b00111, 1'b0, 1'b0, 5'd4,  4'd1, 5'b00001, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 5'b00111, 1'b0, 1'b0, 5'd3,  4'd2, 5'b00011, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 5'b00111, 1'b0, 1'b1, 5'd2,  4'd3, 5'b00010, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 5'b00111, 1'b0, 1'b1, 5'd1,  4'd4, 5'b00110, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 5'b00111, 1'b1, 1'b1, 5'd0,  4'd5, 5'b00111, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 5'b00111, 1'b1, 1'b1, 5'd0,  4'd5, 5'b00111, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 5'b00111, 1'b1, 1'b1, 5'd0,  4'd5, 5'b00111, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 5'b00000, 1'b1, 1'b1, 5'd0,  4'd0, 5'b00000, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 5'b00011, 1'b0, 1'b1, 5'd2,  4'd0, 5'b00000, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 5'b00011, 1'b0, 1'b1, 5'd1,  4'd1, 5'b00001, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 5'b00011, 1'b1, 1'b1, 5'd0,  4'd2, 5'b00011, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 5'b01101, 1'b0, 1'b0, 5'd7,  4'd2, 5'b00011, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 5'b01101, 1'b1, 1'b1, 5'd0,  4'd9, 5'b01101, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 5'b11000, 1'b0, 1'b0, 5'd7,  4'd9, 5'b01101, 1'b0};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 5'b11000, 1'b1, 1'b1, 5'd0,  4'd0, 5'b00000, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 5'b11000, 1'b0, 1'b0, 5'd16, 4'd0, 5'b00000, 1'b0};

        rst = 1'b1; inc = 1'b0; flush = 1'b0; wg = 5'b00000;

        for (int i = 0; i < 19; i++) begin
            rst = tbl[i].rst; inc = tbl[i].inc; flush = tbl[i].flush; wg = tbl[i].wg;
            step();
            chk("empty", i, 32'(empty), 32'(tbl[i].e));
            chk("almost_empty", i, 32'(ae), 32'(tbl[i].ae));
            chk("level", i, 32'(level), 32'(tbl[i].lvl));
            chk("addr", i, 32'(addr), 32'(tbl[i].addr));
            chk("gray", i, 32'(gray), 32'(tbl[i].g));
            chk("underflow", i, 32'(uf), 32'(tbl[i].uf & UFE));
        end

        // Wrap: keep the write pointer 4 ahead while popping every cycle for 40 cycles
        rst = 1'b1; inc = 1'b0; flush = 1'b0; wg = 5'b00000;
        step();
        step();
        rst = 1'b0; wg = to_gray(5'd4);
        step();
        chk("wrap_start_level", 0, 32'(level), 32'd4);
        begin
            logic [4:0] wb;
            logic [4:0] rb;
            wb = 5'd4;
            rb = 5'd0;
            for (int i = 0; i < 40; i++) begin
                wb = wb + 5'd1;
                rb = rb + 5'd1;
                wg = to_gray(wb);
                inc = 1'b1;
                step();
                chk("wrap_addr", i, 32'(addr), 32'(rb[3:0]));
                chk("wrap_gray", i, 32'(gray), 32'(to_gray(rb)));
                chk("wrap_empty", i, 32'(empty), 32'd0);
                chk("wrap_level", i, 32'(level), 32'd4);
            end
        end
        inc = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
